seq_adder_32bit: RTL and testbench
==================================

# seq_adder_32bit

Multi-cycle wide adder that feeds the team's 8-bit ripple-carry adder (`fulladder_8bit`) one byte slice per clock. It registers the carry between slices and assembles an `8*NUM_BYTES`-bit sum. Operands enter and results leave through valid/ready handshakes. The block sits between the operand source and the result consumer, so wide additions reuse a single 8-bit RCA instead of a full-width ripple chain.

## Interface
- `NUM_BYTES`, default 4: number of byte slices; data width `W = 8*NUM_BYTES`; legal range 1..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands `a`, `b`, `cin` are valid.
- `in_ready` output 1: block accepts operands this cycle.
- `a` input W: operand A.
- `b` input W: operand B.
- `cin` input 1: carry into the least-significant byte.
- `out_valid` output 1: `sum` and `cout` are valid.
- `out_ready` input 1: consumer accepts the result this cycle.
- `sum` output W: registered result `a+b+cin` mod 2^W.
- `cout` output 1: registered carry out of the most-significant byte.

## Operation
- Exactly one `fulladder_8bit` instance. Its inputs are the low bytes of the operand shift registers and the carry register.
- FSM states:
  - IDLE: `in_ready`=1.
  - ADD: a slice is computed each cycle.
  - DONE: `out_valid`=1.
- IDLE→ADD on `in_valid & in_ready`. At that edge:
  - latch `a`, `b` into the shift registers;
  - carry_reg←`cin`, byte index←0;
  - `sum`/`cout` keep their previous values until overwritten.
- Each ADD cycle:
  - shift the adder's 8-bit sum into the top byte of the sum register, shifting the register right by 8;
  - carry_reg←adder cout;
  - shift both operand registers right by 8;
  - index←index+1.
- ADD→DONE on the cycle that processes index `NUM_BYTES-1`. On that edge `cout`←adder cout, and the sum register holds all bytes in order.
- DONE→IDLE on `out_ready`. `sum`/`cout` hold their values until the next result overwrites them.
- `in_ready` = (state==IDLE) & ~`rst`. There is no operand acceptance in ADD or DONE; there is no overlap of transactions.
- `in_valid` and the operand inputs are ignored outside the accept edge. Operands may change freely after acceptance.
- Arithmetic is unsigned modulo 2^W. Signed overflow is not reported.
- Reset values: state IDLE, `out_valid`=0, `sum`=0, `cout`=0, carry_reg=0, index=0, operand registers 0. `in_ready`=0 while `rst`=1 and 1 on the first cycle after release.
- Reset mid-operation (ADD or DONE): the transaction is abandoned and no result is presented. The next cycle behaves as after power-up reset.

## Timing
- Accept edge at cycle t. ADD occupies cycles t+1..t+NUM_BYTES. `out_valid` rises at cycle t+NUM_BYTES+1.
  - Example: with NUM_BYTES=4, accept at edge 0 gives `out_valid` high after edge 4.
- Minimum issue interval: NUM_BYTES+2 cycles (accept, N adds, 1 DONE cycle with `out_ready`=1, then IDLE).
- `out_valid`, `sum`, `cout` are stable while `out_valid`=1 and `out_ready`=0, for any number of stall cycles.
- `out_ready` asserted before `out_valid` has no effect.
- Critical path is one 8-bit ripple plus register setup. There is no combinational path from input ports to output ports except `rst`→`in_ready`.

## Test plan
- Reset: assert `rst` 2 cycles → `out_valid`=0, `sum`=0, `cout`=0, `in_ready`=0; after release `in_ready`=1.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 → after 4 ADD cycles, `sum`=0x00000000, `cout`=1.
- Cin only: a=0x000000FF, b=0x00000000, cin=1 → `sum`=0x00000100, `cout`=0. Additional case: a=0x12345678, b=0x9ABCDEF0, cin=1 → `sum`=0xACF13569, `cout`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `sum`/`cout` unchanged, `in_ready`=0 throughout. Raise `out_ready` → IDLE next cycle, `in_ready`=1.
- Back-to-back: `in_valid` held high with two operand sets, `out_ready`=1 → the second set is accepted only in IDLE; results appear 6 cycles apart and match a reference model.
- Reset mid-op: assert `rst` during the 2nd ADD cycle → `out_valid` never rises for that transaction, `sum`=0. A fresh a=0x80000000, b=0x80000000 → `sum`=0, `cout`=1.

Source files
------------

// File: rtl/seq_adder_32bit.sv
// seq_adder_32bit: multi-cycle wide adder built around one 8-bit ripple-carry adder.
// It accepts a/b/cin on an in_valid/in_ready handshake. It then feeds one byte slice
// per clock through fulladder_8bit and presents sum/cout on an out_valid/out_ready
// handshake.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operands a, b, cin are valid
//   in_ready   : operands accepted this cycle (IDLE and not in reset)
//   a, b       : operands, 8*NUM_BYTES bits
//   cin        : carry into the least-significant byte
//   out_valid  : sum and cout are valid
//   out_ready  : consumer takes the result this cycle
//   sum        : registered a+b+cin mod 2^W
//   cout       : registered carry out of the most-significant byte

// 8-bit ripple-carry adder slice.
module fulladder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // The carry ripples bit by bit through a single chain.
    always_comb begin : ripple
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module seq_adder_32bit #(
    parameter int unsigned NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] a,
    input  logic [8*NUM_BYTES-1:0] b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] sum,
    output logic                   cout
);

    localparam int unsigned W     = 8 * NUM_BYTES;
    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     acc;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [7:0]       fa_sum;
    logic             fa_cout;
    logic             last_slice;
    logic [W+7:0]     acc_ins;
    logic [W-1:0]     acc_nxt;

    fulladder_8bit u_fa (
        .a    (a_sr[7:0]),
        .b    (b_sr[7:0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // rst gates in_ready directly so nothing is accepted on a reset cycle.
    assign in_ready   = (state == IDLE) & ~rst;
    assign last_slice = (idx == LAST_IDX);

    // New byte enters at the top; the concatenation keeps NUM_BYTES=1 legal.
    assign acc_ins = {fa_sum, acc};
    assign acc_nxt = acc_ins[W+7:8];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = ADD;
            ADD:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand shift registers, carry, slice index and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            acc       <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr      <= a;
                        b_sr      <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                ADD: begin
                    a_sr      <= a_sr >> 8;
                    b_sr      <= b_sr >> 8;
                    carry_reg <= fa_cout;
                    acc       <= acc_nxt;
                    idx       <= idx + IDX_W'(1);
                    // sum/cout update only once the full word is assembled.
                    if (last_slice) begin
                        sum       <= acc_nxt;
                        cout      <= fa_cout;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder_32bit.sv
// Self-checking bench for seq_adder_32bit (NUM_BYTES=4) against an arithmetic model.
module tb_seq_adder_32bit;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    seq_adder_32bit #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    // Reference: plain (W+1)-bit addition, carry in the top bit.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    // One transaction with out_ready held high; starts and ends at a negedge in IDLE.
    task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                           input string name);
        logic [W:0] exp;
        int lat;
        exp = model(x, y, c);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_before got %b want 1", name, in_ready);
        end
        a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != NB + 1) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, NB + 1);
        end
        checks++;
        if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL %s result got cout=%b sum=%h want cout=%b sum=%h",
                     name, cout, sum, exp[W], exp[W-1:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got ov=%b sum=%h cout=%b ir=%b want 0 0 0 0",
                     out_valid, sum, cout, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "full_ripple");
        run_txn(32'h0000_00FF, 32'h0000_0000, 1'b1, "cin_only");
        run_txn(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "mixed");
        run_txn(32'h0000_0000, 32'h0000_0000, 1'b0, "zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_txn($urandom, $urandom, 1'($urandom), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   exp;
        int           lat;
        x = $urandom; y = $urandom;
        exp = model(x, y, 1'b1);
        a = x; b = y; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != NB + 1) begin
            errors++;
            $display("FAIL bp_latency got %0d want %0d", lat, NB + 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp) begin
                errors++;
                $display("FAIL bp_stall%0d got ov=%b ir=%b cout=%b sum=%h want 1 0 %b %h",
                         i, out_valid, in_ready, cout, sum, exp[W], exp[W-1:0]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cout, sum} !== exp) begin
            errors++;
            $display("FAIL bp_release got ov=%b ir=%b sum=%h want 0 1 %h",
                     out_valid, in_ready, sum, exp[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sa [2];
        logic [W-1:0] sb [2];
        logic         sc [2];
        logic [W:0]   expq [$];
        int           sent;
        int           got;
        int           last_t;
        for (int i = 0; i < 2; i++) begin
            sa[i] = $urandom; sb[i] = $urandom; sc[i] = 1'($urandom);
        end
        sent = 0; got = 0; last_t = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected result at cycle %0d", cyc);
                end else begin
                    logic [W:0] e;
                    e = expq.pop_front();
                    if ({cout, sum} !== e) begin
                        errors++;
                        $display("FAIL b2b_result got cout=%b sum=%h want cout=%b sum=%h",
                                 cout, sum, e[W], e[W-1:0]);
                    end
                end
                if (last_t >= 0) begin
                    checks++;
                    if (cyc - last_t != NB + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing got %0d want %0d", cyc - last_t, NB + 2);
                    end
                end
                last_t = cyc;
                got++;
            end
            // in_ready seen here means the coming edge accepts what is driven now.
            if (in_ready === 1'b1 && sent < 2) begin
                a = sa[sent]; b = sb[sent]; cin = sc[sent];
                expq.push_back(model(sa[sent], sb[sent], sc[sent]));
                in_valid = 1'b1;
                sent++;
            end else if (in_ready === 1'b1) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d want 2", got);
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        // Leave nonzero sum and cout=1 so the reset clearing them is observable.
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "pre_midop");
        a = $urandom; b = $urandom; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset got ov=%b ir=%b sum=%h cout=%b want 0 0 0 0",
                     out_valid, in_ready, sum, cout);
        end
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || sum !== '0) begin
            errors++;
            $display("FAIL midop_no_result got ov_cycles=%0d sum=%h want 0 0", seen, sum);
        end
        run_txn(32'h8000_0000, 32'h8000_0000, 1'b0, "post_midop");
        checks++;
        if (sum !== 32'h0000_0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL post_midop_const got cout=%b sum=%h want 1 00000000", cout, sum);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
